// File: rtl/vga_pkg.sv
// Shared raster timing sets, sync polarity constants and sizing helpers for the
// VGA timing generator family.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t TIMING_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_timing_t TIMING_1280X720_60 = '{1280, 110, 40, 220, 720, 5, 5, 20};

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int count_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that resets every stage to a caller-chosen idle word,
// so the delayed outputs come out of reset already in their inactive state.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_pixel_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= RESET_VAL;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: a fetch-side coordinate stream and a video
// stream that trails it by FETCH_LEAD cycles so the pixel reader can prefetch.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = TIMING_640X480_60.h_active,
  parameter int H_FP       = TIMING_640X480_60.h_fp,
  parameter int H_SYNC     = TIMING_640X480_60.h_sync,
  parameter int H_BP       = TIMING_640X480_60.h_bp,
  parameter int V_ACTIVE   = TIMING_640X480_60.v_active,
  parameter int V_FP       = TIMING_640X480_60.v_fp,
  parameter int V_SYNC     = TIMING_640X480_60.v_sync,
  parameter int V_BP       = TIMING_640X480_60.v_bp,
  parameter bit HSYNC_POL  = SYNC_ACTIVE_LOW,
  parameter bit VSYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int FETCH_LEAD = 4,
  localparam int H_TOTAL   = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL   = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW        = count_width(H_TOTAL),
  localparam int VW        = count_width(V_TOTAL)
) (
  input  logic          i_pixel_clock,
  input  logic          i_reset_n,
  input  logic          i_enable,
  output logic          o_fetch_valid,
  output logic [HW-1:0] o_fetch_x,
  output logic [VW-1:0] o_fetch_y,
  output logic          o_fetch_frame_start,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [HW-1:0] o_hpos,
  output logic [VW-1:0] o_vpos,
  output logic          o_frame_start,
  output logic          o_line_start
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int DW = 5 + HW + VW;
  localparam logic [DW-1:0] IDLE_WORD = {~HSYNC_POL, ~VSYNC_POL, 3'b000, {HW{1'b0}}, {VW{1'b0}}};

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          active;
  logic          hsync_on;
  logic          vsync_on;
  logic          fetch_hsync;
  logic          fetch_vsync;
  logic          fetch_line_start;
  logic [DW-1:0] fetch_word;
  logic [DW-1:0] video_word;

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!i_enable) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

  assign active   = (hc < H_ACT) && (vc < V_ACT);
  assign hsync_on = (hc >= HS_START) && (hc < HS_END);
  assign vsync_on = (vc >= VS_START) && (vc < VS_END);

  // A stopped raster presents idle values here rather than decoding the parked (0,0).
  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fetch_valid       <= 1'b0;
      o_fetch_x           <= '0;
      o_fetch_y           <= '0;
      o_fetch_frame_start <= 1'b0;
      fetch_hsync         <= ~HSYNC_POL;
      fetch_vsync         <= ~VSYNC_POL;
      fetch_line_start    <= 1'b0;
    end else if (!i_enable) begin
      o_fetch_valid       <= 1'b0;
      o_fetch_x           <= '0;
      o_fetch_y           <= '0;
      o_fetch_frame_start <= 1'b0;
      fetch_hsync         <= ~HSYNC_POL;
      fetch_vsync         <= ~VSYNC_POL;
      fetch_line_start    <= 1'b0;
    end else begin
      o_fetch_valid       <= active;
      o_fetch_x           <= hc;
      o_fetch_y           <= vc;
      o_fetch_frame_start <= (hc == '0) && (vc == '0);
      fetch_hsync         <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
      fetch_vsync         <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
      fetch_line_start    <= (hc == '0) && (vc < V_ACT);
    end
  end

  assign fetch_word = {fetch_hsync, fetch_vsync, o_fetch_valid, fetch_line_start,
                       o_fetch_frame_start, o_fetch_x, o_fetch_y};

  vga_delay_line #(
    .WIDTH     (DW),
    .DEPTH     (FETCH_LEAD),
    .RESET_VAL (IDLE_WORD)
  ) u_video_delay (
    .i_pixel_clock (i_pixel_clock),
    .i_reset_n     (i_reset_n),
    .din           (fetch_word),
    .dout          (video_word)
  );

  assign {o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos} = video_word;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance checked by hand sequences and a tiny
// active-high instance checked by a vector table plus randomized enable against a raster model.
module tb_vga_timing_gen;

  localparam int BHW = 10;
  localparam int BVW = 10;
  localparam int SHW = 4;
  localparam int SVW = 3;
  localparam int S_HT = 15;
  localparam int S_VT = 7;
  localparam int S_LEAD = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic b_rst_n, b_en, s_rst_n, s_en;

  logic           b_fetch_valid, b_fetch_frame_start, b_hsync, b_vsync, b_de, b_frame_start, b_line_start;
  logic [BHW-1:0] b_fetch_x, b_hpos;
  logic [BVW-1:0] b_fetch_y, b_vpos;

  logic           s_fetch_valid, s_fetch_frame_start, s_hsync, s_vsync, s_de, s_frame_start, s_line_start;
  logic [SHW-1:0] s_fetch_x, s_hpos;
  logic [SVW-1:0] s_fetch_y, s_vpos;

  vga_timing_gen u_big (
    .i_pixel_clock       (clk),
    .i_reset_n           (b_rst_n),
    .i_enable            (b_en),
    .o_fetch_valid       (b_fetch_valid),
    .o_fetch_x           (b_fetch_x),
    .o_fetch_y           (b_fetch_y),
    .o_fetch_frame_start (b_fetch_frame_start),
    .o_hsync             (b_hsync),
    .o_vsync             (b_vsync),
    .o_de                (b_de),
    .o_hpos              (b_hpos),
    .o_vpos              (b_vpos),
    .o_frame_start       (b_frame_start),
    .o_line_start        (b_line_start)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .FETCH_LEAD (S_LEAD)
  ) u_small (
    .i_pixel_clock       (clk),
    .i_reset_n           (s_rst_n),
    .i_enable            (s_en),
    .o_fetch_valid       (s_fetch_valid),
    .o_fetch_x           (s_fetch_x),
    .o_fetch_y           (s_fetch_y),
    .o_fetch_frame_start (s_fetch_frame_start),
    .o_hsync             (s_hsync),
    .o_vsync             (s_vsync),
    .o_de                (s_de),
    .o_hpos              (s_hpos),
    .o_vpos              (s_vpos),
    .o_frame_start       (s_frame_start),
    .o_line_start        (s_line_start)
  );

  typedef struct packed {
    logic           hs;
    logic           vs;
    logic           de;
    logic           ls;
    logic           fs;
    logic [SHW-1:0] x;
    logic [SVW-1:0] y;
  } vid_t;

  typedef struct {
    int k;
    int hpos, vpos;
    bit de, hs, vs, fs, ls;
    bit fv, ffs;
    int fx, fy;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  bit   model_check = 1'b0;
  int   mp;
  vid_t m_fetch, m_video;
  vid_t mq[$];

  vec_t tbl [15];
  int   k;
  int   fv_rise, de_rise, hs_min, hs_max, hs_cnt, vs_low, ls_cnt, lead_err, guard;
  int   de_cnt [3];
  int   fx_hist[$];
  int   fy_hist[$];

  function automatic vid_t s_decode(input int p);
    int x, y;
    vid_t v;
    x    = p % S_HT;
    y    = (p / S_HT) % S_VT;
    v.x  = SHW'(x);
    v.y  = SVW'(y);
    v.de = (x < 8) && (y < 4);
    v.hs = (x >= 10) && (x < 13);
    v.vs = (y == 5);
    v.fs = (x == 0) && (y == 0);
    v.ls = (x == 0) && (y < 4);
    return v;
  endfunction

  function automatic vid_t pack_vid(input bit hs, input bit vs, input bit de, input bit ls,
                                    input bit fs, input int x, input int y);
    vid_t v;
    v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs;
    v.x  = SHW'(x);
    v.y  = SVW'(y);
    return v;
  endfunction

  function automatic int s_video_now();
    vid_t v;
    v = '{s_hsync, s_vsync, s_de, s_line_start, s_frame_start, s_hpos, s_vpos};
    return int'(v);
  endfunction

  function automatic int s_fetch_now();
    return int'({s_fetch_valid, s_fetch_frame_start, s_fetch_x, s_fetch_y});
  endfunction

  function automatic int fetch_of(input vid_t v);
    return int'({v.de, v.fs, v.x, v.y});
  endfunction

  task automatic model_reset();
    mp      = 0;
    m_fetch = '0;
    m_video = '0;
    mq.delete();
    for (int i = 0; i < S_LEAD - 1; i++) mq.push_back('0);
  endtask

  task automatic model_edge(input logic en);
    mq.push_back(m_fetch);
    m_video = mq.pop_front();
    if (en) begin
      m_fetch = s_decode(mp);
      mp++;
    end else begin
      m_fetch = '0;
      mp      = 0;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    logic en_q, rst_q;
    en_q  = s_en;
    rst_q = s_rst_n;
    @(posedge clk);
    #1;
    if (!rst_q) model_reset();
    else        model_edge(en_q);
    if (model_check) begin
      checkOutput("model_video", s_video_now(), int'(m_video));
      checkOutput("model_fetch", s_fetch_now(), fetch_of(m_fetch));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl = '{
      '{2,   0,  0, 1, 0, 0, 1, 1, 1, 0,  1, 0},
      '{9,   7,  0, 1, 0, 0, 0, 0, 0, 0,  8, 0},
      '{10,  8,  0, 0, 0, 0, 0, 0, 0, 0,  9, 0},
      '{12,  10, 0, 0, 1, 0, 0, 0, 0, 0, 11, 0},
      '{14,  12, 0, 0, 1, 0, 0, 0, 0, 0, 13, 0},
      '{15,  13, 0, 0, 0, 0, 0, 0, 0, 0, 14, 0},
      '{16,  14, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1},
      '{17,  0,  1, 1, 0, 0, 0, 1, 1, 0,  1, 1},
      '{62,  0,  4, 0, 0, 0, 0, 0, 0, 0,  1, 4},
      '{77,  0,  5, 0, 0, 1, 0, 0, 0, 0,  1, 5},
      '{91,  14, 5, 0, 0, 1, 0, 0, 0, 0,  0, 6},
      '{92,  0,  6, 0, 0, 0, 0, 0, 0, 0,  1, 6},
      '{105, 13, 6, 0, 0, 0, 0, 0, 0, 0, 14, 6},
      '{106, 14, 6, 0, 0, 0, 0, 0, 1, 1,  0, 0},
      '{107, 0,  0, 1, 0, 0, 1, 1, 1, 0,  1, 0}
    };

    b_rst_n = 1'b0; b_en = 1'b1;
    s_rst_n = 1'b0; s_en = 1'b1;
    model_reset();
    repeat (3) applyStimulus();

    checkOutput("rst_hsync",   b_hsync, 1);
    checkOutput("rst_vsync",   b_vsync, 1);
    checkOutput("rst_de",      b_de, 0);
    checkOutput("rst_hpos",    int'(b_hpos), 0);
    checkOutput("rst_vpos",    int'(b_vpos), 0);
    checkOutput("rst_strobes", int'({b_frame_start, b_line_start, b_fetch_frame_start}), 0);
    checkOutput("rst_fetch",   int'({b_fetch_valid, b_fetch_x, b_fetch_y}), 0);
    checkOutput("rst_small_video", s_video_now(), 0);

    // Default timing: three lines of free run after reset release.
    b_rst_n  = 1'b1;
    fv_rise  = -1; de_rise = -1;
    hs_min   = 9999; hs_max = -1; hs_cnt = 0;
    vs_low   = 0; ls_cnt = 0; lead_err = 0;
    de_cnt   = '{0, 0, 0};
    for (int c = 1; c <= 2404; c++) begin
      applyStimulus();
      if (fv_rise < 0 && b_fetch_valid) fv_rise = c;
      if (de_rise < 0 && b_de) de_rise = c;
      if (c == 1) checkOutput("first_fetch_frame_start", b_fetch_frame_start, 1);
      if (c == 5) checkOutput("first_frame_start", b_frame_start, 1);
      if (b_de && b_vpos < 10'd3) de_cnt[b_vpos[1:0]]++;
      if (!b_hsync && b_vpos == 10'd1) begin
        hs_cnt++;
        if (int'(b_hpos) < hs_min) hs_min = int'(b_hpos);
        if (int'(b_hpos) > hs_max) hs_max = int'(b_hpos);
      end
      if (!b_vsync) vs_low++;
      if (b_line_start) ls_cnt++;
      fx_hist.push_back(int'(b_fetch_x));
      fy_hist.push_back(int'(b_fetch_y));
      if (c > 4 && (fx_hist[c-5] != int'(b_hpos) || fy_hist[c-5] != int'(b_vpos))) lead_err++;
    end
    checkOutput("fetch_valid_rise", fv_rise, 1);
    checkOutput("lead_cycles",      de_rise - fv_rise, 4);
    checkOutput("de_row0",          de_cnt[0], 640);
    checkOutput("de_row1",          de_cnt[1], 640);
    checkOutput("de_row2",          de_cnt[2], 640);
    checkOutput("hsync_count",      hs_cnt, 96);
    checkOutput("hsync_first_hpos", hs_min, 656);
    checkOutput("hsync_last_hpos",  hs_max, 751);
    checkOutput("vsync_quiet",      vs_low, 0);
    checkOutput("line_start_count", ls_cnt, 3);
    checkOutput("lead_position",    lead_err, 0);

    // Stop the raster with hc=300 on row 3, then restart it.
    guard = 0;
    while (!(b_fetch_x == 10'd299 && b_fetch_y == 10'd3) && guard < 4000) begin
      applyStimulus();
      guard++;
    end
    checkOutput("toggle_reached", int'(guard < 4000), 1);
    b_en = 1'b0;
    applyStimulus();
    checkOutput("stop_fetch_idle", int'({b_fetch_valid, b_fetch_x, b_fetch_y}), 0);
    checkOutput("stop_video_still_on", b_de, 1);
    repeat (3) applyStimulus();
    checkOutput("stop_last_video", int'({b_de, b_hpos, b_vpos}), int'({1'b1, 10'd299, 10'd3}));
    applyStimulus();
    checkOutput("stop_video_idle", int'({b_de, b_hsync, b_hpos, b_vpos}), int'({1'b0, 1'b1, 20'd0}));
    repeat (3) applyStimulus();
    checkOutput("stopped_no_strobe", int'({b_fetch_frame_start, b_frame_start}), 0);
    b_en = 1'b1;
    applyStimulus();
    checkOutput("restart_fetch", int'({b_fetch_frame_start, b_fetch_valid, b_fetch_x, b_fetch_y}),
                int'({2'b11, 20'd0}));
    repeat (3) applyStimulus();
    checkOutput("restart_frame_early", b_frame_start, 0);
    applyStimulus();
    checkOutput("restart_frame_start", int'({b_frame_start, b_de}), 3);

    // Small timing: vector table from reset release, enabled throughout.
    s_rst_n = 1'b1;
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        applyStimulus();
        k++;
      end
      checkOutput($sformatf("tbl_video_k%0d", tbl[i].k), s_video_now(),
                  int'(pack_vid(tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls, tbl[i].fs,
                                tbl[i].hpos, tbl[i].vpos)));
      checkOutput($sformatf("tbl_fetch_k%0d", tbl[i].k), s_fetch_now(),
                  int'({tbl[i].fv, tbl[i].ffs, SHW'(tbl[i].fx), SVW'(tbl[i].fy)}));
    end

    // Asynchronous reset in the middle of an active line.
    repeat (3) applyStimulus();
    checkOutput("midline_active", int'({s_de, s_hpos}), int'({1'b1, 4'd3}));
    #3;
    s_rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_rst_video", s_video_now(), 0);
    checkOutput("async_rst_fetch", s_fetch_now(), 0);
    applyStimulus();

    // Randomized enable against the raster model.
    s_rst_n     = 1'b1;
    model_check = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      s_en = ($urandom_range(0, 15) != 0);
      applyStimulus();
    end
    model_check = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
